switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 15: number of switch inputs conditioned; matches the 15-bit switch bus of the gate-test top level.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required before a level is accepted (10 ms at 100 MHz); legal range 1 to 2^24-1.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port IN, input, WIDTH bits: raw, asynchronous, bouncing switch levels.
REQ-006 SHALL have port OUT, output, WIDTH bits: debounced, synchronous switch levels; feeds the gate-test top level's IN bus.
REQ-007 SHALL have port RISE, output, WIDTH bits: one-cycle pulse per bit when that OUT bit goes 0->1.
REQ-008 SHALL have port FALL, output, WIDTH bits: one-cycle pulse per bit when that OUT bit goes 1->0.
REQ-009 SHALL have port CHG, output, 1 bit: one-cycle pulse when any OUT bit changes; equals OR-reduce(RISE|FALL).

Function
REQ-010 Each IN bit SHALL pass through a two-flop synchronizer (S1, S2); no logic between S1 and S2.
REQ-011 Each bit SHALL own an independent counter of width clog2(DEBOUNCE_CYCLES+1); bits SHALL NOT share or interact.
REQ-012 When S2 equals OUT for a bit, its counter SHALL be cleared to 0 on the next edge.
REQ-013 When S2 differs from OUT, the counter SHALL increment by 1 per edge; on the edge where it would reach DEBOUNCE_CYCLES, OUT SHALL invert and the counter SHALL clear to 0 in the same edge.
REQ-014 Latency: for an IN level held stable, OUT SHALL change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level into S1.
REQ-015 Any glitch returning S2 to the OUT level before the count completes SHALL clear the counter; OUT SHALL NOT change, and the next mismatch SHALL restart from 0.
REQ-016 The counter SHALL never exceed DEBOUNCE_CYCLES and SHALL never wrap.
REQ-017 RISE/FALL SHALL be registered, asserted in the cycle immediately after the edge on which OUT changed, for exactly one cycle.
REQ-018 Several bits completing on the same edge SHALL each assert their own RISE/FALL bit in the same cycle, with a single one-cycle CHG.
REQ-019 With DEBOUNCE_CYCLES=1, OUT SHALL follow S2 with one edge of delay (latency 3).

Reset
REQ-020 While RST is high, S1, S2, all counters, OUT, RISE, FALL and CHG SHALL be 0, regardless of CLK.
REQ-021 Reset asserted mid-count SHALL discard the partial count; after release, counting SHALL restart from 0.
REQ-022 After release with an IN bit already high, that OUT bit SHALL rise after DEBOUNCE_CYCLES+2 edges and SHALL pulse RISE.
REQ-023 Reset release SHALL be the only event that leaves synchronizer state undefined-free; no X SHALL appear on any output after reset.

Structure
REQ-024 A shared package SHALL hold the default WIDTH (15), default DEBOUNCE_CYCLES, and the counter-width function clog2.
REQ-025 One sub-module debounce_bit SHALL implement REQ-010..REQ-017 for one bit; the top level SHALL instantiate it WIDTH times and OR-reduce CHG.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-026 Hold RST high, toggle IN and CLK -> OUT/RISE/FALL/CHG stay 0; release with IN=0 -> all outputs remain 0 for 20 cycles.
REQ-027 IN[0] 0->1 held stable -> OUT[0]=1 exactly 6 edges after the first sampling edge; RISE[0] and CHG high for one cycle; the other OUT bits stay 0.
REQ-028 IN[3] rises, bounces low after 3 cycles, then rises and holds -> no OUT[3] change on the first attempt; OUT[3]=1 six edges after the final rise.
REQ-029 IN[14:0] 0 -> 15'h7FFF in one cycle -> all OUT bits rise on the same edge; RISE=15'h7FFF for one cycle and a single CHG pulse.
REQ-030 OUT[5]=1, IN[5] falls, RST asserted asynchronously after 2 cycles, released with IN[5]=1 -> OUT[5]=0 immediately; it returns to 1 after 6 edges with a RISE[5] pulse.
REQ-031 Random IN toggling with a period under 4 cycles for 1000 cycles -> OUT never changes; the counter never exceeds 4.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// switch_debouncer_pkg
// Shared defaults and helpers for the switch debouncer.
//   DEFAULT_WIDTH           : number of switches on the board switch bus (15)
//   DEFAULT_DEBOUNCE_CYCLES : stable cycles needed to accept a level
//                             (10 ms at 100 MHz); legal range 1 .. 2^24-1
//   clog2()                 : bit width needed to hold values 0 .. value-1,
//                             never less than 1
// ---------------------------------------------------------------------------
package switch_debouncer_pkg;

  localparam int unsigned DEFAULT_WIDTH           = 15;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

  // Ceiling log2. Constant-foldable, so it can size counters at elaboration.
  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// Conditions one raw switch input: two-flop synchronizer followed by a
// saturating stability counter. The debounced level only flips after the
// synchronized input has disagreed with it for DEBOUNCE_CYCLES consecutive
// edges; any agreement in between clears the count.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears every flop
//   din   : raw, asynchronous switch level
//   dout  : debounced level
//   rise  : registered one-cycle pulse, set on the edge dout goes 0->1
//   fall  : registered one-cycle pulse, set on the edge dout goes 1->0
// ---------------------------------------------------------------------------
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES + 1);

  logic             s1_q,   s1_d;
  logic             s2_q,   s2_d;
  logic             out_q,  out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  always_comb begin
    // Synchronizer stages are plain wires between flops.
    s1_d   = din;
    s2_d   = s1_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      // This edge would be the DEBOUNCE_CYCLES-th mismatch: accept the new
      // level and restart from zero instead of storing the terminal count.
      cnt_d  = '0;
      out_d  = ~out_q;
      rise_d = ~out_q;
      fall_d = out_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
// Debounces a bus of WIDTH independent mechanical switches. Each bit has its
// own synchronizer and counter; bits never interact.
// Parameters:
//   WIDTH           : number of switch inputs
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a level, 1..2^24-1
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   IN   : raw switch levels
//   OUT  : debounced levels (changes DEBOUNCE_CYCLES+2 edges after IN is
//          first sampled, for a stable input)
//   RISE : one-cycle pulse per bit when OUT goes 0->1 (same cycle OUT is new)
//   FALL : one-cycle pulse per bit when OUT goes 1->0
//   CHG  : one-cycle pulse when any OUT bit changed; OR of RISE|FALL
// ---------------------------------------------------------------------------
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH           = DEFAULT_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHG
);

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (CLK),
      .rst  (RST),
      .din  (IN[i]),
      .dout (OUT[i]),
      .rise (RISE[i]),
      .fall (FALL[i])
    );
  end

  // RISE/FALL are already registered, so CHG is a clean single-cycle pulse
  // even when many bits complete on the same edge.
  assign CHG = |(RISE | FALL);

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4 (15-bit bus)
// plus a 1-bit instance with DEBOUNCE_CYCLES=1 for the minimum-latency case.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_bus = '0;
  logic [W-1:0] out_bus, rise_bus, fall_bus;
  logic         chg;

  logic [0:0]   in_min = '0;
  logic [0:0]   out_min, rise_min, fall_min;
  logic         chg_min;

  int checks = 0;
  int errors = 0;

  // ---------------- clock/reset block ----------------
  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
    .CLK  (clk),
    .RST  (rst),
    .IN   (in_bus),
    .OUT  (out_bus),
    .RISE (rise_bus),
    .FALL (fall_bus),
    .CHG  (chg)
  );

  switch_debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(1)) dut_min (
    .CLK  (clk),
    .RST  (rst),
    .IN   (in_min),
    .OUT  (out_min),
    .RISE (rise_min),
    .FALL (fall_min),
    .CHG  (chg_min)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_bus = (i % 2 == 0) ? 15'h7FFF : 15'h2A55;
      in_min = 1'(i % 2 == 0);
      tick();
      checks++;
      if ({out_bus, rise_bus, fall_bus, chg} !== '0) begin
        errors++;
        $display("FAIL reset_hold: out=%h rise=%h fall=%h chg=%b, required all 0",
                 out_bus, rise_bus, fall_bus, chg);
      end
      checks++;
      if ({out_min, rise_min, fall_min, chg_min} !== 4'b0) begin
        errors++;
        $display("FAIL reset_hold_min: out=%b rise=%b fall=%b chg=%b, required 0",
                 out_min, rise_min, fall_min, chg_min);
      end
    end
    in_bus = '0;
    in_min = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({out_bus, rise_bus, fall_bus, chg} !== '0) begin
        errors++;
        $display("FAIL reset_release cycle %0d: out=%h rise=%h fall=%h chg=%b, required all 0",
                 i, out_bus, rise_bus, fall_bus, chg);
      end
    end
  endtask

  task automatic test_single_rise();
    in_bus[0] = 1'b1;
    repeat (5) tick();
    checks++;
    if (out_bus !== 15'h0000) begin
      errors++;
      $display("FAIL single_rise_early: out=%h, required 0000", out_bus);
    end
    tick();
    checks++;
    if (out_bus !== 15'h0001 || rise_bus !== 15'h0001 || fall_bus !== 15'h0000 || chg !== 1'b1) begin
      errors++;
      $display("FAIL single_rise_edge6: out=%h rise=%h fall=%h chg=%b, required 0001 0001 0000 1",
               out_bus, rise_bus, fall_bus, chg);
    end
    tick();
    checks++;
    if (out_bus !== 15'h0001 || rise_bus !== 15'h0000 || chg !== 1'b0) begin
      errors++;
      $display("FAIL single_rise_pulse_end: out=%h rise=%h chg=%b, required 0001 0000 0",
               out_bus, rise_bus, chg);
    end
  endtask

  task automatic test_glitch();
    // High for 3 sampled edges: the count reaches only 3 before S2 drops.
    in_bus[3] = 1'b1;
    repeat (3) tick();
    in_bus[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_bus !== 15'h0001 || chg !== 1'b0) begin
        errors++;
        $display("FAIL glitch_no_change cycle %0d: out=%h chg=%b, required 0001 0",
                 i, out_bus, chg);
      end
    end
    in_bus[3] = 1'b1;
    repeat (5) tick();
    checks++;
    if (out_bus !== 15'h0001) begin
      errors++;
      $display("FAIL glitch_retry_early: out=%h, required 0001", out_bus);
    end
    tick();
    checks++;
    if (out_bus !== 15'h0009 || rise_bus !== 15'h0008 || chg !== 1'b1) begin
      errors++;
      $display("FAIL glitch_retry_edge6: out=%h rise=%h chg=%b, required 0009 0008 1",
               out_bus, rise_bus, chg);
    end
  endtask

  task automatic test_all_rise();
    int chg_count;
    in_bus = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_bus = 15'h7FFF;
    chg_count = 0;
    repeat (5) begin
      tick();
      if (chg === 1'b1) chg_count++;
    end
    checks++;
    if (out_bus !== 15'h0000) begin
      errors++;
      $display("FAIL all_rise_early: out=%h, required 0000", out_bus);
    end
    tick();
    if (chg === 1'b1) chg_count++;
    checks++;
    if (out_bus !== 15'h7FFF || rise_bus !== 15'h7FFF || fall_bus !== 15'h0000 || chg !== 1'b1) begin
      errors++;
      $display("FAIL all_rise_edge6: out=%h rise=%h fall=%h chg=%b, required 7fff 7fff 0000 1",
               out_bus, rise_bus, fall_bus, chg);
    end
    repeat (10) begin
      tick();
      if (chg === 1'b1) chg_count++;
    end
    checks++;
    if (chg_count !== 1 || rise_bus !== 15'h0000) begin
      errors++;
      $display("FAIL all_rise_single_chg: chg pulses=%0d rise=%h, required 1 0000",
               chg_count, rise_bus);
    end
  endtask

  task automatic test_reset_mid_count();
    in_bus[5] = 1'b0;
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_bus !== 15'h0000 || rise_bus !== 15'h0000 || fall_bus !== 15'h0000 || chg !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%h rise=%h fall=%h chg=%b, required all 0",
               out_bus, rise_bus, fall_bus, chg);
    end
    in_bus = 15'h7FFF;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (out_bus !== 15'h0000) begin
      errors++;
      $display("FAIL reset_restart_early: out=%h, required 0000", out_bus);
    end
    tick();
    checks++;
    if (out_bus[5] !== 1'b1 || rise_bus[5] !== 1'b1 || chg !== 1'b1) begin
      errors++;
      $display("FAIL reset_restart_edge6: out[5]=%b rise[5]=%b chg=%b, required 1 1 1",
               out_bus[5], rise_bus[5], chg);
    end
    tick();
    checks++;
    if (rise_bus[5] !== 1'b0 || out_bus !== 15'h7FFF) begin
      errors++;
      $display("FAIL reset_restart_pulse_end: rise[5]=%b out=%h, required 0 7fff",
               rise_bus[5], out_bus);
    end
  endtask

  task automatic test_bounce();
    int rem [W];
    for (int b = 0; b < W; b++) rem[b] = 0;
    for (int c = 0; c < 1000; c++) begin
      // Each level lasts 1..3 cycles, always shorter than the 4-cycle window.
      for (int b = 0; b < W; b++) begin
        if (rem[b] == 0) begin
          in_bus[b] = ~in_bus[b];
          rem[b] = $urandom_range(1, 3);
        end
        rem[b]--;
      end
      tick();
      checks++;
      if (out_bus !== 15'h7FFF || chg !== 1'b0) begin
        errors++;
        $display("FAIL bounce_stable cycle %0d: out=%h chg=%b, required 7fff 0", c, out_bus, chg);
      end
      checks++;
      if (dut.gen_bit[0].u_bit.cnt_q >= 3'd4 || dut.gen_bit[7].u_bit.cnt_q >= 3'd4 ||
          dut.gen_bit[14].u_bit.cnt_q >= 3'd4) begin
        errors++;
        $display("FAIL bounce_count cycle %0d: cnt0=%0d cnt7=%0d cnt14=%0d, required < 4", c,
                 dut.gen_bit[0].u_bit.cnt_q, dut.gen_bit[7].u_bit.cnt_q, dut.gen_bit[14].u_bit.cnt_q);
      end
    end
    in_bus = 15'h7FFF;
    repeat (8) tick();
    checks++;
    if (out_bus !== 15'h7FFF) begin
      errors++;
      $display("FAIL bounce_settle: out=%h, required 7fff", out_bus);
    end
  endtask

  task automatic test_fall();
    in_bus[7] = 1'b0;
    repeat (5) tick();
    checks++;
    if (out_bus !== 15'h7FFF) begin
      errors++;
      $display("FAIL fall_early: out=%h, required 7fff", out_bus);
    end
    tick();
    checks++;
    if (out_bus !== 15'h7F7F || fall_bus !== 15'h0080 || rise_bus !== 15'h0000 || chg !== 1'b1) begin
      errors++;
      $display("FAIL fall_edge6: out=%h fall=%h rise=%h chg=%b, required 7f7f 0080 0000 1",
               out_bus, fall_bus, rise_bus, chg);
    end
    tick();
    checks++;
    if (fall_bus !== 15'h0000 || chg !== 1'b0) begin
      errors++;
      $display("FAIL fall_pulse_end: fall=%h chg=%b, required 0000 0", fall_bus, chg);
    end
  endtask

  task automatic test_min_cycles();
    in_min = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_min !== 1'b0) begin
      errors++;
      $display("FAIL min_rise_early: out=%b, required 0", out_min);
    end
    tick();
    checks++;
    if (out_min !== 1'b1 || rise_min !== 1'b1 || chg_min !== 1'b1) begin
      errors++;
      $display("FAIL min_rise_edge3: out=%b rise=%b chg=%b, required 1 1 1",
               out_min, rise_min, chg_min);
    end
    in_min = 1'b0;
    repeat (2) tick();
    checks++;
    if (out_min !== 1'b1) begin
      errors++;
      $display("FAIL min_fall_early: out=%b, required 1", out_min);
    end
    tick();
    checks++;
    if (out_min !== 1'b0 || fall_min !== 1'b1 || chg_min !== 1'b1) begin
      errors++;
      $display("FAIL min_fall_edge3: out=%b fall=%b chg=%b, required 0 1 1",
               out_min, fall_min, chg_min);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_all_rise();
    test_reset_mid_count();
    test_bounce();
    test_fall();
    test_min_cycles();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
